// File: rtl/air_hockey_pkg.sv
// Shared air-hockey table constants and the paddle controller FSM encoding.
package air_hockey_pkg;

  localparam int TBL_W        = 12;
  localparam int TBL_X_MIN    = 0;
  localparam int TBL_X_MAX    = 1023;
  localparam int TBL_Y_MIN    = 0;
  localparam int TBL_Y_MAX    = 767;
  localparam int TBL_MAX_STEP = 16;
  localparam int TBL_HOME_X   = 512;
  localparam int TBL_HOME_Y   = 384;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CLAMP  = 2'd1;
  localparam state_t ST_STEP   = 2'd2;
  localparam state_t ST_UPDATE = 2'd3;

endpackage

// File: rtl/paddle_motion_ctl_if.sv
// Mouse-in / paddle-state-out bundle between the mouse front end and draw/physics.
interface paddle_motion_ctl_if #(parameter int W = 12);
  logic                frame_tick;
  logic                enable;
  logic                home;
  logic [W-1:0]        mouse_xpos;
  logic [W-1:0]        mouse_ypos;
  logic [W-1:0]        xpos;
  logic [W-1:0]        ypos;
  logic signed [W:0]   vel_x;
  logic signed [W:0]   vel_y;
  logic                upd;
  logic                overrun;

  modport master (
    output frame_tick, enable, home, mouse_xpos, mouse_ypos,
    input  xpos, ypos, vel_x, vel_y, upd, overrun
  );

  modport slave (
    input  frame_tick, enable, home, mouse_xpos, mouse_ypos,
    output xpos, ypos, vel_x, vel_y, upd, overrun
  );
endinterface

// File: rtl/axis_limiter.sv
// One axis: clamp a raw coordinate into [MIN, MAX] and rate-limit the move toward a target.
module axis_limiter #(
  parameter int W        = 12,
  parameter int MIN      = 0,
  parameter int MAX      = 1023,
  parameter int MAX_STEP = 16
) (
  input  logic [W-1:0]      i_raw,
  input  logic [W-1:0]      i_tgt,
  input  logic [W-1:0]      i_pos,
  output logic [W-1:0]      o_clamped,
  output logic signed [W:0] o_step
);

  localparam logic [W-1:0]      LO     = MIN[W-1:0];
  localparam logic [W-1:0]      HI     = MAX[W-1:0];
  localparam logic signed [W:0] STEP_P = MAX_STEP[W:0];
  localparam logic signed [W:0] STEP_N = -STEP_P;

  // Borrow bits of the W+1 subtractions act as the unsigned range compares.
  logic [W:0]          w_dlo, w_dhi;
  logic signed [W:0]   w_diff;

  assign w_dlo  = {1'b0, i_raw} - {1'b0, LO};
  assign w_dhi  = {1'b0, HI} - {1'b0, i_raw};
  assign w_diff = $signed({1'b0, i_tgt}) - $signed({1'b0, i_pos});

  always_comb begin
    o_clamped = i_raw;
    if (w_dlo[W])      o_clamped = LO;
    else if (w_dhi[W]) o_clamped = HI;
  end

  always_comb begin
    o_step = w_diff;
    if (w_diff > STEP_P)      o_step = STEP_P;
    else if (w_diff < STEP_N) o_step = STEP_N;
  end

endmodule

// File: rtl/paddle_motion_ctl.sv
// Frame-synchronous paddle position controller: capture, clamp, rate-limit, publish.
module paddle_motion_ctl
  import air_hockey_pkg::*;
#(
  parameter int W        = TBL_W,
  parameter int X_MIN    = TBL_X_MIN,
  parameter int X_MAX    = TBL_X_MAX,
  parameter int Y_MIN    = TBL_Y_MIN,
  parameter int Y_MAX    = TBL_Y_MAX,
  parameter int MAX_STEP = TBL_MAX_STEP,
  parameter int HOME_X   = TBL_HOME_X,
  parameter int HOME_Y   = TBL_HOME_Y
) (
  input logic               clk,
  input logic               rst,
  paddle_motion_ctl_if.slave bus
);

  state_t              r_state;
  logic [W-1:0]        r_raw_x, r_raw_y, r_tgt_x, r_tgt_y, r_xpos, r_ypos;
  logic signed [W:0]   r_vel_x, r_vel_y;
  logic                r_en, r_home, r_upd, r_overrun;
  logic [W-1:0]        w_clamp_x, w_clamp_y;
  logic signed [W:0]   w_step_x, w_step_y;

  axis_limiter #(.W(W), .MIN(X_MIN), .MAX(X_MAX), .MAX_STEP(MAX_STEP)) u_lim_x (
    .i_raw(r_raw_x), .i_tgt(r_tgt_x), .i_pos(r_xpos),
    .o_clamped(w_clamp_x), .o_step(w_step_x)
  );

  axis_limiter #(.W(W), .MIN(Y_MIN), .MAX(Y_MAX), .MAX_STEP(MAX_STEP)) u_lim_y (
    .i_raw(r_raw_y), .i_tgt(r_tgt_y), .i_pos(r_ypos),
    .o_clamped(w_clamp_y), .o_step(w_step_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_raw_x   <= '0;
      r_raw_y   <= '0;
      r_tgt_x   <= '0;
      r_tgt_y   <= '0;
      r_en      <= 1'b0;
      r_home    <= 1'b0;
      r_xpos    <= HOME_X[W-1:0];
      r_ypos    <= HOME_Y[W-1:0];
      r_vel_x   <= '0;
      r_vel_y   <= '0;
      r_upd     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (bus.frame_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: if (bus.frame_tick) begin
          r_raw_x <= bus.mouse_xpos;
          r_raw_y <= bus.mouse_ypos;
          r_en    <= bus.enable;
          r_home  <= bus.home;
          r_state <= ST_CLAMP;
        end
        ST_CLAMP: begin
          r_tgt_x <= w_clamp_x;
          r_tgt_y <= w_clamp_y;
          r_state <= ST_STEP;
        end
        // Outputs land here so upd is high during UPDATE, three cycles after the tick.
        ST_STEP: begin
          if (r_home) begin
            r_xpos  <= HOME_X[W-1:0];
            r_ypos  <= HOME_Y[W-1:0];
            r_vel_x <= '0;
            r_vel_y <= '0;
          end else if (!r_en) begin
            r_vel_x <= '0;
            r_vel_y <= '0;
          end else begin
            r_xpos  <= r_xpos + w_step_x[W-1:0];
            r_ypos  <= r_ypos + w_step_y[W-1:0];
            r_vel_x <= w_step_x;
            r_vel_y <= w_step_y;
          end
          r_upd   <= 1'b1;
          r_state <= ST_UPDATE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.xpos    = r_xpos;
  assign bus.ypos    = r_ypos;
  assign bus.vel_x   = r_vel_x;
  assign bus.vel_y   = r_vel_y;
  assign bus.upd     = r_upd;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_paddle_motion_ctl.sv
// Randomized + directed bench for paddle_motion_ctl against a frame-level position model.
module tb_paddle_motion_ctl;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  paddle_motion_ctl_if #(.W(W)) bus();

  paddle_motion_ctl #(
    .W(W), .X_MIN(0), .X_MAX(1023), .Y_MIN(0), .Y_MAX(767),
    .MAX_STEP(16), .HOME_X(512), .HOME_Y(384)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errs   = 0;
  int checks = 0;
  int px = 512, py = 384, pvx = 0, pvy = 0, povr = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model(input int rx, input int ry, input bit en, input bit hm);
    int dx, dy;
    if (hm) begin
      px = 512; py = 384; pvx = 0; pvy = 0;
    end else if (!en) begin
      pvx = 0; pvy = 0;
    end else begin
      dx  = lim(lim(rx, 0, 1023) - px, -16, 16);
      dy  = lim(lim(ry, 0, 767) - py, -16, 16);
      px += dx; py += dy; pvx = dx; pvy = dy;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".x"},   int'(bus.xpos), px);
    chk({tag, ".y"},   int'(bus.ypos), py);
    chk({tag, ".vx"},  int'(bus.vel_x), pvx);
    chk({tag, ".vy"},  int'(bus.vel_y), pvy);
    chk({tag, ".ovr"}, int'(bus.overrun), povr);
  endtask

  // One frame: tick, scramble inputs after capture, expect upd on the 3rd cycle.
  task automatic frame(input int rx, input int ry, input bit en, input bit hm, input string tag);
    int lat;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.mouse_xpos = rx[W-1:0];
    bus.mouse_ypos = ry[W-1:0];
    bus.enable     = en;
    bus.home       = hm;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.mouse_xpos = W'($urandom);
    bus.mouse_ypos = W'($urandom);
    bus.enable     = 1'($urandom);
    bus.home       = 1'($urandom);
    lat = 1;
    while (!bus.upd && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, 3);
    model(rx, ry, en, hm);
    chk_state(tag);
    @(negedge clk);
    chk({tag, ".upd_drop"}, int'(bus.upd), 0);
  endtask

  initial begin
    int ups, upd_at;
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b1;
    bus.home       = 1'b0;
    bus.mouse_xpos = '0;
    bus.mouse_ypos = '0;
    repeat (3) @(negedge clk);
    chk("rst.upd", int'(bus.upd), 0);
    chk_state("rst");
    rst = 1'b0;

    frame(600, 400, 1, 0, "first");
    chk("first.x_abs", int'(bus.xpos), 528);
    chk("first.vx_abs", int'(bus.vel_x), 16);

    for (int i = 0; i < 36; i++) frame(2000, 900, 1, 0, "climb");
    chk("climb.x_max", int'(bus.xpos), 1023);
    chk("climb.y_max", int'(bus.ypos), 767);
    chk("climb.vx0", int'(bus.vel_x), 0);

    for (int i = 0; i < 60 && !(px == 100 && py == 100); i++) frame(100, 100, 1, 0, "to100");
    frame(0, 95, 1, 0, "low");
    chk("low.x_abs", int'(bus.xpos), 84);
    chk("low.vy_abs", int'(bus.vel_y), -5);
    for (int i = 0; i < 7; i++) frame(0, 95, 1, 0, "floor");
    chk("floor.x_min", int'(bus.xpos), 0);

    for (int i = 0; i < 60 && !(px == 900 && py == 700); i++) frame(900, 700, 1, 0, "to900");
    frame(0, 0, 1, 1, "home");
    chk("home.x_abs", int'(bus.xpos), 512);
    for (int i = 0; i < 3; i++) frame(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 0, 0, "frozen");

    // Back-to-back ticks: the second one is dropped and flags overrun.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.mouse_xpos = 12'd700;
    bus.mouse_ypos = 12'd500;
    bus.enable     = 1'b1;
    bus.home       = 1'b0;
    ups = 0; upd_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.upd) begin ups++; upd_at = i; end
      if (i == 1) begin
        bus.mouse_xpos = 12'd0;
        bus.mouse_ypos = 12'd0;
      end else begin
        bus.frame_tick = 1'b0;
      end
    end
    model(700, 500, 1, 0);
    povr = 1;
    chk("ovr.ups", ups, 1);
    chk("ovr.at", upd_at, 3);
    chk_state("ovr");
    frame(300, 300, 1, 0, "ovr_sticky");

    // Reset while the update is in flight.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.mouse_xpos = 12'd0;
    bus.mouse_ypos = 12'd0;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    px = 512; py = 384; pvx = 0; pvy = 0; povr = 0;
    chk("abort.upd", int'(bus.upd), 0);
    chk_state("abort");
    ups = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.upd) ups++;
    end
    chk("abort.no_upd", ups, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      frame(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/paddle_motion_ctl.md
Name: paddle_motion_ctl

Overview:
- Frame-synchronous paddle position controller for the air-hockey table; successor to the plain mouse-to-position register.
- Samples mouse coordinates on each frame tick, clamps them to a parametrised play area, and rate-limits motion to MAX_STEP pixels per frame per axis.
- Publishes position plus a signed per-frame velocity for the puck collision logic and the paddle drawing block.
- Sits between the mouse interface and the draw/physics pipeline, one instance per player.

Parameters:
- W, 12, coordinate width in bits (unsigned positions).
- X_MIN, 0, lowest legal paddle centre x.
- X_MAX, 1023, highest legal paddle centre x.
- Y_MIN, 0, lowest legal paddle centre y.
- Y_MAX, 767, highest legal paddle centre y.
- MAX_STEP, 16, maximum |displacement| per axis per frame; range 1..2^(W-1)-1.
- HOME_X, 512, reset/home x.
- HOME_Y, 384, reset/home y.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- enable  in  1  game running; 0 freezes paddle.
- home  in  1  level; recentres paddle at next update.
- mouse_xpos  in  W  raw mouse x.
- mouse_ypos  in  W  raw mouse y.
- xpos  out  W  paddle centre x.
- ypos  out  W  paddle centre y.
- vel_x  out  W+1  signed x step applied at last update.
- vel_y  out  W+1  signed y step applied at last update.
- upd  out  1  one-cycle pulse when xpos/ypos/vel change.
- overrun  out  1  sticky; frame_tick arrived while busy.

Behaviour:
- Reset values: xpos=HOME_X, ypos=HOME_Y, vel_x=vel_y=0, upd=0, overrun=0, FSM=IDLE. rst mid-operation aborts the update; no upd pulse is issued.
- IDLE: on frame_tick, capture mouse_xpos/mouse_ypos, enable and home into internal registers, then go to CLAMP. Mouse inputs are not used after this capture cycle.
- CLAMP: per axis, target = MIN if raw < MIN, MAX if raw > MAX, else raw. Comparisons are unsigned W-bit. Go to STEP.
- STEP: per axis, diff = target − pos, computed signed W+1.
  - Step = +MAX_STEP if diff > MAX_STEP, −MAX_STEP if diff < −MAX_STEP, else diff.
  - Captured home=1 overrides: pos := HOME, vel := 0, no rate limit.
  - Captured enable=0 (and home=0): pos unchanged, vel := 0.
  - Go to UPDATE.
- UPDATE: register new xpos/ypos/vel_x/vel_y, assert upd for exactly this cycle, return to IDLE.
- Latency: frame_tick at cycle t gives new outputs and upd=1 at cycle t+3. Outputs are stable between updates.
- frame_tick in CLAMP/STEP/UPDATE: the tick is ignored and overrun is set to 1. overrun clears only on rst.
- Boundaries:
  - diff exactly ±MAX_STEP passes unclamped.
  - Target equal to pos gives vel 0, and upd still pulses.
  - Positions never leave [MIN, MAX], because pos starts legal and steps move toward a legal target.
- X and Y are processed in parallel within each state.

Decomposition:
- Shared package air_hockey_pkg holds:
  - FSM state typedef (IDLE, CLAMP, STEP, UPDATE).
  - Default table bounds and HOME constants used by both paddles and the puck.
- One sub-module is natural: axis_limiter (parameters W, MIN, MAX, MAX_STEP).
  - Contains the clamp and rate-limit logic for one axis.
  - Instantiated twice, for x and y.

Test Plan:
- Reset release, then frame_tick with mouse (600,400) -> cycle t+3: upd=1, xpos=528, ypos=400, vel_x=+16, vel_y=+16; next cycle upd=0.
- Mouse held at (2000,900), repeated ticks -> x climbs by 16 per frame to exactly 1023, y climbs to exactly 767; then vel=0 and upd still pulses each frame.
- Paddle at (100,100), mouse (0,95) -> xpos=84 (vel −16), ypos=95 (vel −5); after further frames xpos=X_MIN=0, never wraps.
- Paddle at (900,700), home=1, tick -> (512,384) in one update with vel 0. With enable=0 and mouse moving -> position frozen, vel 0.
- Second frame_tick at t+1 -> ignored, overrun=1 and stays set; only one upd pulse. rst asserted at t+2 -> outputs return to HOME, no upd, overrun=0.
